// File: rtl/vga_timing_pkg.sv
// Shared types and default 640x480@60 timing for the VGA scan controller.
// Imported by vga_timing_ctrl; the frame counter is enabled with VGA_FRAME_CNT_EN.
package vga_timing_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RUN       = 2'd1,
        STOP_PEND = 2'd2
    } vga_state_e;

    localparam logic [15:0] DEF_H_ACTIVE = 16'd640;
    localparam logic [15:0] DEF_H_FP     = 16'd16;
    localparam logic [15:0] DEF_H_SYNC   = 16'd96;
    localparam logic [15:0] DEF_H_BP     = 16'd48;
    localparam logic [15:0] DEF_V_ACTIVE = 16'd480;
    localparam logic [15:0] DEF_V_FP     = 16'd10;
    localparam logic [15:0] DEF_V_SYNC   = 16'd2;
    localparam logic [15:0] DEF_V_BP     = 16'd33;

    localparam logic [15:0] DEF_H_TOTAL     = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam logic [15:0] DEF_V_TOTAL     = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
    localparam logic [15:0] DEF_HSYNC_START = DEF_H_ACTIVE + DEF_H_FP;
    localparam logic [15:0] DEF_HSYNC_END   = DEF_HSYNC_START + DEF_H_SYNC - 16'd1;
    localparam logic [15:0] DEF_VSYNC_START = DEF_V_ACTIVE + DEF_V_FP;
    localparam logic [15:0] DEF_VSYNC_END   = DEF_VSYNC_START + DEF_V_SYNC - 16'd1;

    // Inclusive window test used for both sync pulses.
    function automatic logic inWindow(input logic [15:0] pos,
                                      input logic [15:0] lo,
                                      input logic [15:0] hi);
        return (pos >= lo) && (pos <= hi);
    endfunction

endpackage

// File: rtl/vga_timing_ctrl_axis_counter.sv
// Single scan axis counter: counts enabled ticks 0..TERMINAL and flags the wrapping tick.
// Exposes the next count so the parent can register outputs aligned with the count.
module vga_axis_counter #(
    parameter int unsigned          WIDTH    = 16,
    parameter logic [WIDTH-1:0]     TERMINAL = '1
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             en_i,
    output logic [WIDTH-1:0] count_o,
    output logic [WIDTH-1:0] next_o,
    output logic             wrap_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        wrap_o  = en_i && (count_q == TERMINAL);
        count_d = count_q;
        if (en_i) begin
            count_d = (count_q == TERMINAL) ? '0 : count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign next_o  = count_d;

endmodule

// File: rtl/vga_timing_ctrl.sv
// VGA scan timing controller with run/stop sequencing that stops only at a frame boundary.
// Define VGA_FRAME_CNT_EN to add the completed-frame counter output frame_cnt_o.
module vga_timing_ctrl
    import vga_timing_pkg::*;
#(
    parameter logic [15:0] H_ACTIVE  = DEF_H_ACTIVE,
    parameter logic [15:0] H_FP      = DEF_H_FP,
    parameter logic [15:0] H_SYNC    = DEF_H_SYNC,
    parameter logic [15:0] H_BP      = DEF_H_BP,
    parameter logic [15:0] V_ACTIVE  = DEF_V_ACTIVE,
    parameter logic [15:0] V_FP      = DEF_V_FP,
    parameter logic [15:0] V_SYNC    = DEF_V_SYNC,
    parameter logic [15:0] V_BP      = DEF_V_BP,
    parameter logic        HSYNC_POL = 1'b0,
    parameter logic        VSYNC_POL = 1'b0
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        pix_en_i,
    input  logic        run_i,
    output logic [15:0] h_count_o,
    output logic [15:0] v_count_o,
    output logic        hsync_o,
    output logic        vsync_o,
    output logic        video_on_o,
    output logic        line_end_o,
    output logic        frame_end_o,
`ifdef VGA_FRAME_CNT_EN
    output logic [15:0] frame_cnt_o,
`endif
    output logic        busy_o
);

    localparam logic [15:0] H_TOTAL     = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam logic [15:0] V_TOTAL     = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam logic [15:0] HSYNC_START = H_ACTIVE + H_FP;
    localparam logic [15:0] HSYNC_END   = HSYNC_START + H_SYNC - 16'd1;
    localparam logic [15:0] VSYNC_START = V_ACTIVE + V_FP;
    localparam logic [15:0] VSYNC_END   = VSYNC_START + V_SYNC - 16'd1;

    vga_state_e  state_q, state_d;
    logic        hsync_q, vsync_q, videoOn_q;
    logic        tick, hWrap, vWrap, lineEnd, frameEnd;
    logic [15:0] hCount, vCount, hNext, vNext;

    // Gating with reset keeps the strobes quiet while reset is applied.
    assign tick     = rst_n_i && pix_en_i && (state_q != IDLE);
    assign lineEnd  = hWrap;
    assign frameEnd = hWrap && vWrap;

    vga_axis_counter #(.WIDTH(16), .TERMINAL(H_TOTAL - 16'd1)) uHCounter (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .en_i    (tick),
        .count_o (hCount),
        .next_o  (hNext),
        .wrap_o  (hWrap)
    );

    vga_axis_counter #(.WIDTH(16), .TERMINAL(V_TOTAL - 16'd1)) uVCounter (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .en_i    (lineEnd),
        .count_o (vCount),
        .next_o  (vNext),
        .wrap_o  (vWrap)
    );

    // A run request arriving on the final tick of a pending stop keeps scanning.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:      if (run_i) state_d = RUN;
            RUN:       if (!run_i) state_d = STOP_PEND;
            STOP_PEND: begin
                if (run_i)         state_d = RUN;
                else if (frameEnd) state_d = IDLE;
            end
            default:   state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q   <= IDLE;
            hsync_q   <= ~HSYNC_POL;
            vsync_q   <= ~VSYNC_POL;
            videoOn_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            hsync_q   <= inWindow(hNext, HSYNC_START, HSYNC_END) ? HSYNC_POL : ~HSYNC_POL;
            vsync_q   <= inWindow(vNext, VSYNC_START, VSYNC_END) ? VSYNC_POL : ~VSYNC_POL;
            videoOn_q <= (state_d != IDLE) && (hNext < H_ACTIVE) && (vNext < V_ACTIVE);
        end
    end

`ifdef VGA_FRAME_CNT_EN
    logic [15:0] frameCnt_q;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            frameCnt_q <= '0;
        end else if (frameEnd) begin
            frameCnt_q <= frameCnt_q + 16'd1;
        end
    end

    assign frame_cnt_o = frameCnt_q;
`endif

    assign h_count_o   = hCount;
    assign v_count_o   = vCount;
    assign hsync_o     = hsync_q;
    assign vsync_o     = vsync_q;
    assign video_on_o  = videoOn_q;
    assign line_end_o  = lineEnd;
    assign frame_end_o = frameEnd;
    assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Self-checking bench for vga_timing_ctrl using a reduced timing so whole frames fit in a short run.
// Build with VGA_FRAME_CNT_EN defined to also check the frame counter.
module tb_vga_timing_ctrl;

    localparam int HA  = 16;
    localparam int HFP = 4;
    localparam int HS  = 6;
    localparam int HBP = 6;
    localparam int HT  = HA + HFP + HS + HBP;
    localparam int VA  = 12;
    localparam int VFP = 2;
    localparam int VS  = 2;
    localparam int VBP = 4;
    localparam int VT  = VA + VFP + VS + VBP;

    typedef struct {
        logic        known;
        logic [15:0] h;
        logic [15:0] v;
        logic        hs;
        logic        vs;
        logic        vid;
        logic        busy;
        logic        le;
        logic        fe;
        logic [15:0] fc;
    } exp_t;

    logic        clk;
    logic        rstN;
    logic        pixEn;
    logic        run;
    logic [15:0] hCount;
    logic [15:0] vCount;
    logic        hsync;
    logic        vsync;
    logic        videoOn;
    logic        lineEnd;
    logic        frameEnd;
    logic        busy;
`ifdef VGA_FRAME_CNT_EN
    logic [15:0] frameCnt;
`endif

    exp_t        sbQueue[$];
    int          checkCount = 0;
    int          errorCount = 0;

    int          mState  = 0;
    int          mH      = 0;
    int          mV      = 0;
    logic [15:0] mFrames = '0;
    bit          mKnown  = 1'b0;

    logic        obsLe, obsFe, obsHs, obsVs, obsVid, obsBusy;
    logic [15:0] obsH, obsV;

    vga_timing_ctrl #(
        .H_ACTIVE (16'(HA)),  .H_FP (16'(HFP)), .H_SYNC (16'(HS)), .H_BP (16'(HBP)),
        .V_ACTIVE (16'(VA)),  .V_FP (16'(VFP)), .V_SYNC (16'(VS)), .V_BP (16'(VBP)),
        .HSYNC_POL(1'b0),     .VSYNC_POL(1'b0)
    ) dut (
        .clk_i       (clk),
        .rst_n_i     (rstN),
        .pix_en_i    (pixEn),
        .run_i       (run),
        .h_count_o   (hCount),
        .v_count_o   (vCount),
        .hsync_o     (hsync),
        .vsync_o     (vsync),
        .video_on_o  (videoOn),
        .line_end_o  (lineEnd),
        .frame_end_o (frameEnd),
`ifdef VGA_FRAME_CNT_EN
        .frame_cnt_o (frameCnt),
`endif
        .busy_o      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            if (errorCount <= 40)
                $display("[TB] FAIL %s got %0h expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic compareOutputs();
        exp_t e;
        e = sbQueue.pop_front();
        obsLe = lineEnd;  obsFe = frameEnd; obsHs = hsync;  obsVs = vsync;
        obsVid = videoOn; obsBusy = busy;   obsH = hCount;  obsV = vCount;
        if (e.known) begin
            checkOutput("h_count",   32'(hCount),   32'(e.h));
            checkOutput("v_count",   32'(vCount),   32'(e.v));
            checkOutput("hsync",     32'(hsync),    32'(e.hs));
            checkOutput("vsync",     32'(vsync),    32'(e.vs));
            checkOutput("video_on",  32'(videoOn),  32'(e.vid));
            checkOutput("busy",      32'(busy),     32'(e.busy));
            checkOutput("line_end",  32'(lineEnd),  32'(e.le));
            checkOutput("frame_end", 32'(frameEnd), 32'(e.fe));
`ifdef VGA_FRAME_CNT_EN
            checkOutput("frame_cnt", 32'(frameCnt), 32'(e.fc));
`endif
        end
    endtask

    // Drive one clock of inputs, queue the expected view of this cycle, compare, then advance the model.
    task automatic applyStimulus(input logic r, input logic p, input logic ru);
        exp_t e;
        logic tk;
        rstN = r; pixEn = p; run = ru;
        tk     = r && p && (mState != 0);
        e.known = mKnown;
        e.h    = 16'(mH);
        e.v    = 16'(mV);
        e.hs   = (mH >= HA + HFP && mH <= HA + HFP + HS - 1) ? 1'b0 : 1'b1;
        e.vs   = (mV >= VA + VFP && mV <= VA + VFP + VS - 1) ? 1'b0 : 1'b1;
        e.vid  = (mState != 0) && (mH < HA) && (mV < VA);
        e.busy = (mState != 0);
        e.le   = tk && (mH == HT - 1);
        e.fe   = e.le && (mV == VT - 1);
        e.fc   = mFrames;
        sbQueue.push_back(e);
        @(negedge clk);
        compareOutputs();
        if (!r) begin
            mState = 0; mH = 0; mV = 0; mFrames = '0; mKnown = 1'b1;
        end else begin
            if (tk) begin
                if (mH == HT - 1) begin
                    mH = 0;
                    if (mV == VT - 1) begin
                        mV = 0;
                        mFrames = mFrames + 16'd1;
                    end else begin
                        mV++;
                    end
                end else begin
                    mH++;
                end
            end
            case (mState)
                0: if (ru) mState = 1;
                1: if (!ru) mState = 2;
                2: if (ru) mState = 1; else if (e.fe) mState = 0;
                default: mState = 0;
            endcase
        end
        @(posedge clk);
        #1;
    endtask

    // Runs with run held high and measures strobe spacing and pulse widths in clocks.
    task automatic watchTiming(input int nCycles, input int pp);
        int prevLe = 0, prevFe = 0, hsLow = 0, vsLow = 0, vidCnt = 0;
        bit lineSeen = 1'b0, frameSeen = 1'b0;
        for (int i = 0; i < nCycles; i++) begin
            applyStimulus(1'b1, (i % pp) == 0, 1'b1);
            if (!obsHs) hsLow++;
            if (!obsVs) vsLow++;
            if (obsVid) vidCnt++;
            if (obsLe) begin
                if (lineSeen) begin
                    checkOutput("line_gap",    32'(i - prevLe), 32'(HT * pp));
                    checkOutput("hsync_width", 32'(hsLow),      32'(HS * pp));
                end
                checkOutput("le_at_hmax", 32'(obsH), 32'(HT - 1));
                lineSeen = 1'b1; prevLe = i; hsLow = 0;
            end
            if (obsFe) begin
                if (frameSeen) begin
                    checkOutput("frame_gap",   32'(i - prevFe), 32'(HT * VT * pp));
                    checkOutput("vsync_width", 32'(vsLow),      32'(VS * HT * pp));
                    checkOutput("video_count", 32'(vidCnt),     32'(HA * VA * pp));
                end
                frameSeen = 1'b1; prevFe = i; vsLow = 0; vidCnt = 0;
            end
        end
        checkOutput("frames_seen", 32'(frameSeen), 32'd1);
    endtask

    initial begin
        int guard;
        int idleCycles;
        int frames;
        rstN = 1'b0; pixEn = 1'b1; run = 1'b1;
        #1;

        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b1);
        checkOutput("rst_h",     32'(hCount),   32'd0);
        checkOutput("rst_v",     32'(vCount),   32'd0);
        checkOutput("rst_hsync", 32'(hsync),    32'd1);
        checkOutput("rst_vsync", 32'(vsync),    32'd1);
        checkOutput("rst_video", 32'(videoOn),  32'd0);
        checkOutput("rst_busy",  32'(busy),     32'd0);
        checkOutput("rst_le",    32'(lineEnd),  32'd0);
        checkOutput("rst_fe",    32'(frameEnd), 32'd0);

        $display("[TB] full-rate line and frame timing");
        watchTiming(2 * HT * VT + 50, 1);
        $display("[TB] half-rate pixel enable");
        watchTiming(2 * 2 * HT * VT + 100, 2);

        $display("[TB] stop request completes the frame");
        guard = 0;
        while (mV != 5 && guard < 2 * HT * VT) begin applyStimulus(1'b1, 1'b1, 1'b1); guard++; end
        checkOutput("stop_start_v", 32'(vCount), 32'd5);
        guard = 0;
        while (busy && guard < 2 * HT * VT) begin applyStimulus(1'b1, 1'b1, 1'b0); guard++; end
        checkOutput("stop_busy",  32'(busy),   32'd0);
        checkOutput("stop_h",     32'(hCount), 32'd0);
        checkOutput("stop_v",     32'(vCount), 32'd0);
        checkOutput("stop_len",   32'(guard),  32'((VT - 5) * HT));
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("idle_hold_h", 32'(hCount), 32'd0);

        $display("[TB] stop cancelled mid-frame");
        idleCycles = 0;
        applyStimulus(1'b1, 1'b1, 1'b1);
        guard = 0;
        while (mV != 5 && guard < 2 * HT * VT) begin applyStimulus(1'b1, 1'b1, 1'b1); guard++; end
        guard = 0;
        while (mV != 10 && guard < 2 * HT * VT) begin
            applyStimulus(1'b1, 1'b1, 1'b0); guard++;
            if (!obsBusy) idleCycles++;
        end
        for (int i = 0; i < 2 * HT * VT; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b1);
            if (!obsBusy) idleCycles++;
        end
        checkOutput("cancel_idle_cycles", 32'(idleCycles), 32'd0);

        $display("[TB] run wins on the final tick of a pending stop");
        applyStimulus(1'b1, 1'b1, 1'b0);
        guard = 0;
        while (!(mH == HT - 1 && mV == VT - 1) && guard < 2 * HT * VT) begin
            applyStimulus(1'b1, 1'b1, 1'b0); guard++;
        end
        applyStimulus(1'b1, 1'b1, 1'b1);
        checkOutput("runwins_fe",   32'(obsFe),  32'd1);
        checkOutput("runwins_busy", 32'(busy),   32'd1);
        checkOutput("runwins_h",    32'(hCount), 32'd0);
        applyStimulus(1'b1, 1'b1, 1'b1);
        checkOutput("runwins_adv",  32'(hCount), 32'd1);

        $display("[TB] mid-frame reset with pixel enable low");
        guard = 0;
        while (!(mH == 10 && mV == 6) && guard < 2 * HT * VT) begin applyStimulus(1'b1, 1'b1, 1'b1); guard++; end
        applyStimulus(1'b1, 1'b0, 1'b1);
        checkOutput("pre_rst_video", 32'(videoOn), 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("mid_rst_h",     32'(hCount),  32'd0);
        checkOutput("mid_rst_v",     32'(vCount),  32'd0);
        checkOutput("mid_rst_busy",  32'(busy),    32'd0);
        checkOutput("mid_rst_video", 32'(videoOn), 32'd0);
        checkOutput("mid_rst_hsync", 32'(hsync),   32'd1);

        $display("[TB] three complete frames after reset");
        frames = 0; guard = 0;
        while (frames < 3 && guard < 4 * HT * VT) begin
            applyStimulus(1'b1, 1'b1, 1'b1); guard++;
            if (obsFe) frames++;
        end
        checkOutput("three_frames", 32'(frames), 32'd3);
`ifdef VGA_FRAME_CNT_EN
        checkOutput("frame_cnt_3", 32'(frameCnt), 32'd3);
`endif

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog got timeout expected completion");
        $fatal(1, "[TB] simulation time limit reached");
    end

endmodule
